// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped 32-line instruction cache controller with 4-beat line refill.
// Valid bits are held here so flush and reset never depend on the RAM contents.
module icache_ctrl (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_req,
    input  logic [15:0]  i_addr,
    output logic         o_ack,
    output logic [31:0]  o_data,
    input  logic         i_flush,
    output logic         o_mem_req,
    output logic [15:0]  o_mem_addr,
    input  logic         i_mem_ack,
    input  logic [31:0]  i_mem_data,
    output logic [4:0]   o_ram_addr,
    output logic [137:0] o_ram_wdata,
    output logic         o_ram_we,
    input  logic [137:0] i_ram_rdata
);
    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, WRITE} state_t;
    state_t         state, state_nx;
    logic [15:0]    addr_q;
    logic [31:0]    valid;
    logic [1:0]     beat;
    logic           stale;
    logic [127:0]   line_q;
    logic [31:0]    data_q;
    logic [8:0]     tag;
    logic [4:0]     idx;
    logic [1:0]     off;
    logic           hit;
    logic           unused;
    assign tag = addr_q[15:7];
    assign idx = addr_q[6:2];
    assign off = addr_q[1:0];
    assign unused = i_ram_rdata[137];
    // A flush in the lookup cycle must not let a line that is being invalidated hit.
    assign hit = valid[idx] && !i_flush && i_ram_rdata[136:128] == tag;
    always_comb begin
        state_nx    = state;
        o_ack       = 1'b0;
        o_data      = data_q;
        o_mem_req   = 1'b0;
        o_mem_addr  = '0;
        o_ram_we    = 1'b0;
        o_ram_wdata = '0;
        o_ram_addr  = idx;
        case (state)
            IDLE: begin
                if (i_req && i_rst_n) begin
                    o_ram_addr = i_addr[6:2];
                    state_nx   = LOOKUP;
                end
            end
            LOOKUP: begin
                o_ack    = hit;
                o_data   = hit ? i_ram_rdata[32*off +: 32] : data_q;
                state_nx = hit ? IDLE : REFILL;
            end
            REFILL: begin
                o_mem_req  = 1'b1;
                o_mem_addr = {tag, idx, beat};
                state_nx   = (i_mem_ack && beat == 2'd3) ? WRITE : REFILL;
            end
            default: begin
                o_ram_we    = 1'b1;
                o_ram_wdata = {1'b1, tag, line_q};
                o_ack       = 1'b1;
                o_data      = line_q[32*off +: 32];
                state_nx    = IDLE;
            end
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            valid  <= '0;
            beat   <= '0;
            stale  <= 1'b0;
            line_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_nx;
            if (o_ack)
                data_q <= o_data;
            if (state == IDLE && i_req)
                addr_q <= i_addr;
            if (state == LOOKUP) begin
                beat  <= '0;
                stale <= 1'b0;
            end else if (state == REFILL && i_mem_ack) begin
                line_q[32*beat +: 32] <= i_mem_data;
                beat                  <= beat + 2'd1;
            end
            if ((state == REFILL || state == WRITE) && i_flush)
                stale <= 1'b1;
            valid <= i_flush ? '0 : (state == WRITE && !stale) ? (valid | (32'd1 << idx)) : valid;
        end
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed table plus randomized fetches against a line-level cache model,
// with a behavioural RAM and a wait-state-programmable refill memory.
module tb_icache_ctrl;
    logic         i_clk, i_rst_n, i_req, i_flush, i_mem_ack;
    logic [15:0]  i_addr;
    logic         o_ack, o_mem_req, o_ram_we;
    logic [31:0]  o_data, i_mem_data;
    logic [15:0]  o_mem_addr;
    logic [4:0]   o_ram_addr;
    logic [137:0] o_ram_wdata, i_ram_rdata;

    icache_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_addr(i_addr),
        .o_ack(o_ack), .o_data(o_data), .i_flush(i_flush),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
        .i_mem_data(i_mem_data), .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
        .o_ram_we(o_ram_we), .i_ram_rdata(i_ram_rdata)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0]  bmem [65536];
    logic [137:0] ram [32];
    logic [15:0]  waits = '0;
    logic [3:0]   wcnt = '0;
    logic [3:0]   cur_w;
    logic [15:0]  cur_addr = '0;
    logic [1:0]   nb = '0;
    int           n_beats = 0;
    int           n_we = 0;
    logic         prev_wait = 1'b0;
    logic [15:0]  prev_addr = '0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // RAM: synchronous read, registered output, no reset
    always @(posedge i_clk) begin
        if (o_ram_we)
            ram[o_ram_addr] <= o_ram_wdata;
        i_ram_rdata <= ram[o_ram_addr];
    end

    // Refill memory: beat b is accepted after waits[b] stall cycles
    always_comb cur_w = waits[{o_mem_addr[1:0], 2'b00} +: 4];
    assign i_mem_ack  = o_mem_req && (wcnt == cur_w);
    assign i_mem_data = o_mem_req ? bmem[o_mem_addr] : 32'h0;
    always @(posedge i_clk)
        wcnt <= (o_mem_req && !i_mem_ack) ? wcnt + 4'd1 : 4'd0;

    always @(negedge i_clk) begin
        #2;
        if (o_mem_req && prev_wait)
            chk("mem_addr_hold", o_mem_addr, prev_addr);
        if (o_mem_req && i_mem_ack) begin
            chk("mem_beat_addr", o_mem_addr, {cur_addr[15:2], nb});
            nb = nb + 2'd1;
            n_beats++;
        end
        prev_wait = o_mem_req && !i_mem_ack;
        prev_addr = o_mem_addr;
        if (o_ram_we) begin
            chk("ram_we_idx", o_ram_addr, cur_addr[6:2]);
            chk("ram_wdata_hdr", o_ram_wdata[137:128], {1'b1, cur_addr[15:7]});
            n_we++;
        end
    end

    task automatic fetch(input logic [15:0] a, input logic [15:0] w, input int fa,
                         output int lat, output logic [31:0] d, output logic acked);
        waits = w; cur_addr = a; nb = '0; n_beats = 0; n_we = 0;
        i_addr = a; i_req = 1'b1; lat = 0; d = '0; acked = 1'b0;
        for (int c = 1; c <= 200 && !acked; c++) begin
            @(negedge i_clk);
            i_flush = (c == fa);
            #1;
            if (o_ack) begin
                acked = 1'b1;
                lat = c + 1;
                d = o_data;
            end
        end
        @(posedge i_clk);
        #1;
        i_req = 1'b0;
        i_flush = 1'b0;
        @(negedge i_clk);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] w;
        int          fa;
        logic        hit;
        int          lat;
        logic [31:0] data;
    } vec_t;
    vec_t tbl [15];

    logic       m_valid [32];
    logic [8:0] m_tag [32];

    initial begin
        int lat;
        logic [31:0] d;
        logic acked, found, pred_hit, applied;
        logic [15:0] a;
        logic [4:0] idx;
        logic [8:0] tg;
        int fa, sum;
        logic [15:0] w;
        for (int i = 0; i < 65536; i++) bmem[i] = {16'(i) ^ 16'h5A5A, 16'(i)};
        for (int i = 0; i < 4; i++) bmem[16'h1234 + i] = 32'hA0 + i;
        for (int i = 0; i < 32; i++) ram[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
        tbl[0]  = '{16'h1234, 16'h0000, 0, 1'b0,  7, 32'h000000A0};
        tbl[1]  = '{16'h1235, 16'h0000, 0, 1'b1,  2, 32'h000000A1};
        tbl[2]  = '{16'h12B4, 16'h0000, 0, 1'b0,  7, 32'h48EE12B4};
        tbl[3]  = '{16'h1234, 16'h0000, 0, 1'b0,  7, 32'h000000A0};
        tbl[4]  = '{16'h1237, 16'h0000, 0, 1'b1,  2, 32'h000000A3};
        tbl[5]  = '{16'h2222, 16'h5130, 0, 1'b0, 16, 32'h78782222};
        tbl[6]  = '{16'h2220, 16'h0000, 0, 1'b1,  2, 32'h787A2220};
        tbl[7]  = '{16'h2221, 16'h0000, 1, 1'b0,  7, 32'h787B2221};
        tbl[8]  = '{16'h2221, 16'h0000, 0, 1'b1,  2, 32'h787B2221};
        tbl[9]  = '{16'h1237, 16'h0000, 0, 1'b0,  7, 32'h000000A3};
        tbl[10] = '{16'h3330, 16'h2222, 5, 1'b0, 15, 32'h696A3330};
        tbl[11] = '{16'h3330, 16'h0000, 0, 1'b0,  7, 32'h696A3330};
        tbl[12] = '{16'h3333, 16'h0000, 0, 1'b1,  2, 32'h69693333};
        tbl[13] = '{16'h1234, 16'h0000, 6, 1'b0,  7, 32'h000000A0};
        tbl[14] = '{16'h1234, 16'h0000, 0, 1'b0,  7, 32'h000000A0};

        i_rst_n = 1'b0; i_req = 1'b0; i_flush = 1'b0; i_addr = '0;
        @(negedge i_clk); @(negedge i_clk); #1;
        chk("rst_outs", {o_ack, o_mem_req, o_ram_we, o_data, o_mem_addr, o_ram_addr},
            '0);
        chk("rst_wdata", o_ram_wdata[63:0] | o_ram_wdata[127:64] | 64'(o_ram_wdata[137:128]), '0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int r = 0; r < 15; r++) begin
            fetch(tbl[r].addr, tbl[r].w, tbl[r].fa, lat, d, acked);
            chk($sformatf("row%0d_lat", r), lat, tbl[r].lat);
            chk($sformatf("row%0d_data", r), d, tbl[r].data);
            chk($sformatf("row%0d_beats", r), n_beats, tbl[r].hit ? 0 : 4);
            chk($sformatf("row%0d_we", r), n_we, tbl[r].hit ? 0 : 1);
        end

        // Reset in the middle of a refill, on beat 2
        fetch(16'h4440, 16'h0000, 0, lat, d, acked);
        fetch(16'h4441, 16'h0000, 0, lat, d, acked);
        chk("pre_rst_hit_lat", lat, 2);
        waits = 16'h0500; cur_addr = 16'h5550; nb = '0; n_beats = 0; n_we = 0;
        i_addr = 16'h5550; i_req = 1'b1; found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge i_clk); #1;
            if (o_mem_req && o_mem_addr[1:0] == 2'd2) found = 1'b1;
        end
        chk("rst_reach_beat2", found, 1'b1);
        i_rst_n = 1'b0;
        #1;
        chk("rst_async_mem_req", o_mem_req, 1'b0);
        chk("rst_async_ack_we", {o_ack, o_ram_we}, 2'b00);
        i_req = 1'b0;
        @(posedge i_clk); @(negedge i_clk);
        chk("rst_no_ram_write", n_we, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        fetch(16'h4441, 16'h0000, 0, lat, d, acked);
        chk("post_rst_miss_lat", lat, 7);
        chk("post_rst_data", d, bmem[16'h4441]);

        // Random fetches against a line-level model, starting from an empty cache
        i_flush = 1'b1; @(negedge i_clk); i_flush = 1'b0; @(negedge i_clk);
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < 32; i++) m_tag[i] = '0;
        for (int n = 0; n < 80; n++) begin
            tg = 9'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: idx = 5'h0D;
                1: idx = 5'h03;
                2: idx = 5'h1F;
                default: idx = 5'h00;
            endcase
            a = {tg, idx, 2'($urandom_range(0, 3))};
            w = 16'($urandom) & 16'h3333;
            fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            sum = 0;
            for (int b = 0; b < 4; b++) sum += int'(w[4*b +: 4]);
            pred_hit = m_valid[idx] && m_tag[idx] == tg && fa != 1;
            fetch(a, w, fa, lat, d, acked);
            chk($sformatf("rnd%0d_lat", n), lat, pred_hit ? 2 : 7 + sum);
            chk($sformatf("rnd%0d_data", n), d, bmem[a]);
            chk($sformatf("rnd%0d_beats", n), n_beats, pred_hit ? 0 : 4);
            applied = fa != 0 && fa <= (pred_hit ? 1 : 6 + sum);
            if (applied)
                for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
            if (!pred_hit && (!applied || fa == 1)) begin
                m_valid[idx] = 1'b1;
                m_tag[idx] = tg;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
